// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcode/ext fields,
// branch conditions, flag bit positions and the registered control bundle.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_LATCH = 3'd1,
    S_EXEC  = 3'd2,
    S_LDWB  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;
  localparam logic [3:0] EXT_CMP  = 4'b1011;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [15:0] imm;
    logic        imm_sel;
    logic        ram_we;
    logic        ls_addr_sel;
    logic        alu_mem;
    logic        pc_en;
    logic        pc_mux;
    logic [15:0] br;
    logic        load_en;
    logic        halted;
  } ctrl_t;

  function automatic logic is_imm_op(input logic [3:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_MOVI) ||
           (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI);
  endfunction

  function automatic logic imm_is_signed(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI);
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/cpu_control_fsm_branch_cond_eval.sv
// Branch condition evaluator: maps a 4-bit condition code and the latched
// flag register to a taken bit. Unlisted codes are never taken.
module branch_cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [4:0] flags_i,
  output logic       taken_o
);

  logic unused_flags;
  assign unused_flags = ^{flags_i[FLAG_L], flags_i[FLAG_F]};

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_EQ: taken_o = flags_i[FLAG_Z];
      COND_NE: taken_o = !flags_i[FLAG_Z];
      COND_CS: taken_o = flags_i[FLAG_C];
      COND_CC: taken_o = !flags_i[FLAG_C];
      COND_GT: taken_o = flags_i[FLAG_N];
      COND_LE: taken_o = !flags_i[FLAG_N];
      COND_LT: taken_o = !flags_i[FLAG_N] && !flags_i[FLAG_Z];
      COND_GE: taken_o = flags_i[FLAG_N] || flags_i[FLAG_Z];
      COND_UC: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/latch/execute sequencer for the 16-bit datapath.
// Controls are decoded from the next state and registered; en only gates strobes.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int RESET_PC_HOLD = 1,
  parameter int NUM_REGS      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [15:0]         instr_in,
  input  logic [4:0]          flags_in,
  output logic [NUM_REGS-1:0] wEnable,
  output logic [7:0]          opcode,
  output logic [3:0]          Rdest_select,
  output logic [3:0]          Rsrc_select,
  output logic [15:0]         Imm_in,
  output logic                Imm_select,
  output logic                ram_we,
  output logic                ls_addr_sel,
  output logic                fsm_alu_mem_selct,
  output logic                pc_en,
  output logic                pc_mux_selct,
  output logic [15:0]         inst_branch,
  output logic                load_en,
  output logic                halted,
  output logic [2:0]          state_out
);

  state_e              state_q, state_d;
  logic [15:0]         ir_q, ir_d;
  logic [4:0]          flag_q, flag_d;
  logic [7:0]          hold_q, hold_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic [NUM_REGS-1:0] wen_q, wen_d;
  logic                taken;
  logic [3:0]          op_q, op_d, ext_d;

  assign op_q  = ir_q[15:12];
  assign op_d  = ir_d[15:12];
  assign ext_d = ir_d[7:4];

  // Branches look at the flag register that will be current in S_EXEC.
  branch_cond_eval u_cond (
    .cond_i  (ir_d[11:8]),
    .flags_i (flag_d),
    .taken_o (taken)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    flag_d  = flag_q;
    hold_d  = hold_q;
    if (en) begin
      case (state_q)
        S_FETCH: if (hold_q != 8'd0) hold_d = hold_q - 8'd1;
                 else                state_d = S_LATCH;
        S_LATCH: begin
          ir_d    = instr_in;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          if (op_q == OP_RTYPE || is_imm_op(op_q)) flag_d = flags_in;
          if (op_q == OP_MEM && ir_q[7:4] == EXT_LOAD) state_d = S_LDWB;
          else if (op_q == OP_HALT)                     state_d = S_HALT;
          else                                          state_d = S_FETCH;
        end
        S_LDWB:  state_d = S_FETCH;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    ctrl_d = '0;
    wen_d  = '0;
    case (state_d)
      S_LATCH: ctrl_d.load_en = 1'b1;
      S_EXEC: begin
        ctrl_d.pc_en = 1'b1;
        if (op_d == OP_RTYPE) begin
          ctrl_d.opcode  = {op_d, ext_d};
          ctrl_d.rdest   = ir_d[11:8];
          ctrl_d.rsrc    = ir_d[3:0];
          ctrl_d.alu_mem = 1'b1;
          if (ext_d != EXT_CMP) wen_d = {{(NUM_REGS-1){1'b0}}, 1'b1} << ir_d[11:8];
        end else if (is_imm_op(op_d)) begin
          ctrl_d.opcode  = {op_d, 4'b0000};
          ctrl_d.rdest   = ir_d[11:8];
          ctrl_d.imm_sel = 1'b1;
          ctrl_d.imm     = imm_is_signed(op_d) ? sext8(ir_d[7:0]) : {8'h00, ir_d[7:0]};
          ctrl_d.alu_mem = 1'b1;
          if (op_d != OP_CMPI) wen_d = {{(NUM_REGS-1){1'b0}}, 1'b1} << ir_d[11:8];
        end else if (op_d == OP_MEM && ext_d == EXT_LOAD) begin
          ctrl_d.ls_addr_sel = 1'b1;
          ctrl_d.rdest       = ir_d[3:0];
          ctrl_d.pc_en       = 1'b0;
        end else if (op_d == OP_MEM && ext_d == EXT_STOR) begin
          ctrl_d.ls_addr_sel = 1'b1;
          ctrl_d.rdest       = ir_d[3:0];
          ctrl_d.rsrc        = ir_d[11:8];
          ctrl_d.ram_we      = 1'b1;
        end else if (op_d == OP_BCOND) begin
          ctrl_d.br     = sext8(ir_d[7:0]);
          ctrl_d.pc_mux = taken;
        end else if (op_d == OP_HALT) begin
          ctrl_d.pc_en = 1'b0;
        end
      end
      S_LDWB: begin
        // Keep the load address steady while the RAM data is written back.
        ctrl_d.ls_addr_sel = 1'b1;
        ctrl_d.rdest       = ir_d[3:0];
        ctrl_d.pc_en       = 1'b1;
        wen_d              = {{(NUM_REGS-1){1'b0}}, 1'b1} << ir_d[11:8];
      end
      S_HALT:  ctrl_d.halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      flag_q  <= '0;
      hold_q  <= 8'(RESET_PC_HOLD - 1);
      ctrl_q  <= '0;
      wen_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flag_q  <= flag_d;
      hold_q  <= hold_d;
      ctrl_q  <= ctrl_d;
      wen_q   <= wen_d;
    end
  end

  assign wEnable           = wen_q & {NUM_REGS{en}};
  assign ram_we            = ctrl_q.ram_we & en;
  assign pc_en             = ctrl_q.pc_en & en;
  assign load_en           = ctrl_q.load_en & en;
  assign opcode            = ctrl_q.opcode;
  assign Rdest_select      = ctrl_q.rdest;
  assign Rsrc_select       = ctrl_q.rsrc;
  assign Imm_in            = ctrl_q.imm;
  assign Imm_select        = ctrl_q.imm_sel;
  assign ls_addr_sel       = ctrl_q.ls_addr_sel;
  assign fsm_alu_mem_selct = ctrl_q.alu_mem;
  assign pc_mux_selct      = ctrl_q.pc_mux;
  assign inst_branch       = ctrl_q.br;
  assign halted            = ctrl_q.halted;
  assign state_out         = state_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: a vector table of single instructions
// checked in S_EXEC, plus hand sequences for LOAD, STOR/en, reset and HALT.
module tb_cpu_control_fsm;

  logic        clk, reset, en;
  logic [15:0] instr_in;
  logic [4:0]  flags_in;
  logic [15:0] wEnable;
  logic [7:0]  opcode;
  logic [3:0]  Rdest_select, Rsrc_select;
  logic [15:0] Imm_in, inst_branch;
  logic        Imm_select, ram_we, ls_addr_sel, fsm_alu_mem_selct;
  logic        pc_en, pc_mux_selct, load_en, halted;
  logic [2:0]  state_out;

  int total = 0;
  int bad   = 0;
  int cur   = -1;

  cpu_control_fsm #(.RESET_PC_HOLD(1), .NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .en(en), .instr_in(instr_in), .flags_in(flags_in),
    .wEnable(wEnable), .opcode(opcode), .Rdest_select(Rdest_select),
    .Rsrc_select(Rsrc_select), .Imm_in(Imm_in), .Imm_select(Imm_select),
    .ram_we(ram_we), .ls_addr_sel(ls_addr_sel), .fsm_alu_mem_selct(fsm_alu_mem_selct),
    .pc_en(pc_en), .pc_mux_selct(pc_mux_selct), .inst_branch(inst_branch),
    .load_en(load_en), .halted(halted), .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] instr;
    logic [4:0]  flags;
    logic [15:0] wen;
    logic [7:0]  opc;
    logic [15:0] imm;
    logic        isel;
    logic        pcmux;
    logic [15:0] br;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic        chk_rd;
    logic        chk_rs;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [15:0] instr, input logic [4:0] flags,
                              input logic [15:0] wen, input logic [7:0] opc,
                              input logic [15:0] imm, input logic isel, input logic pcmux,
                              input logic [15:0] br, input logic [3:0] rd, input logic [3:0] rs,
                              input logic chk_rd, input logic chk_rs);
    vec_t v;
    v.instr = instr; v.flags = flags; v.wen = wen; v.opc = opc; v.imm = imm;
    v.isel = isel; v.pcmux = pcmux; v.br = br; v.rd = rd; v.rs = rs;
    v.chk_rd = chk_rd; v.chk_rs = chk_rs;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", nm, cur, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in S_FETCH just after a rising edge; leaves back in S_FETCH.
  task automatic run_vec(input vec_t v);
    instr_in = v.instr;
    flags_in = v.flags;
    chk("fetch_state", 16'(state_out), 16'd0);
    chk("fetch_ls", 16'(ls_addr_sel), 16'd0);
    tick();
    chk("latch_state", 16'(state_out), 16'd1);
    chk("latch_load_en", 16'(load_en), 16'd1);
    tick();
    chk("exec_state", 16'(state_out), 16'd2);
    chk("exec_load_en", 16'(load_en), 16'd0);
    chk("exec_pc_en", 16'(pc_en), 16'd1);
    chk("exec_ram_we", 16'(ram_we), 16'd0);
    chk("exec_ls", 16'(ls_addr_sel), 16'd0);
    chk("exec_wen", wEnable, v.wen);
    chk("exec_isel", 16'(Imm_select), 16'(v.isel));
    chk("exec_pcmux", 16'(pc_mux_selct), 16'(v.pcmux));
    if (v.isel) chk("exec_imm", Imm_in, v.imm);
    if (v.instr[15:12] == 4'hC) chk("exec_br", inst_branch, v.br);
    if (v.chk_rd) begin
      chk("exec_opcode", 16'(opcode), 16'(v.opc));
      chk("exec_rdest", 16'(Rdest_select), 16'(v.rd));
    end
    if (v.chk_rs) chk("exec_rsrc", 16'(Rsrc_select), 16'(v.rs));
    if (v.wen != 16'd0) chk("exec_alu_src", 16'(fsm_alu_mem_selct), 16'd1);
    tick();
  endtask

  initial begin
    //            instr    flags     wen      opc    imm      is pm br       rd    rs    crd crs
    tv.push_back(mk(16'h5103, 5'b00000, 16'h0002, 8'h50, 16'h0003, 1, 0, 16'h0000, 4'h1, 4'h0, 1, 0));
    tv.push_back(mk(16'h52FF, 5'b00000, 16'h0004, 8'h50, 16'hFFFF, 1, 0, 16'h0000, 4'h2, 4'h0, 1, 0));
    tv.push_back(mk(16'h22FF, 5'b00000, 16'h0004, 8'h20, 16'h00FF, 1, 0, 16'h0000, 4'h2, 4'h0, 1, 0));
    tv.push_back(mk(16'h0552, 5'b00000, 16'h0020, 8'h05, 16'h0000, 0, 0, 16'h0000, 4'h5, 4'h2, 1, 1));
    // CMP r1,r2 with Z=1, then BEQ -4 taken and BNE not taken
    tv.push_back(mk(16'h01B2, 5'b00010, 16'h0000, 8'h0B, 16'h0000, 0, 0, 16'h0000, 4'h1, 4'h2, 1, 1));
    tv.push_back(mk(16'hC0FC, 5'b00000, 16'h0000, 8'h00, 16'h0000, 0, 1, 16'hFFFC, 4'h0, 4'h0, 0, 0));
    tv.push_back(mk(16'hC1FC, 5'b00000, 16'h0000, 8'h00, 16'h0000, 0, 0, 16'hFFFC, 4'h0, 4'h0, 0, 0));
    tv.push_back(mk(16'hB180, 5'b00000, 16'h0000, 8'hB0, 16'hFF80, 1, 0, 16'h0000, 4'h1, 4'h0, 1, 0));
    tv.push_back(mk(16'hC005, 5'b00000, 16'h0000, 8'h00, 16'h0000, 0, 0, 16'h0005, 4'h0, 4'h0, 0, 0));
    tv.push_back(mk(16'hCE05, 5'b00000, 16'h0000, 8'h00, 16'h0000, 0, 1, 16'h0005, 4'h0, 4'h0, 0, 0));
    tv.push_back(mk(16'hD4AB, 5'b00000, 16'h0010, 8'hD0, 16'h00AB, 1, 0, 16'h0000, 4'h4, 4'h0, 1, 0));
    tv.push_back(mk(16'h7000, 5'b00000, 16'h0000, 8'h00, 16'h0000, 0, 0, 16'h0000, 4'h0, 4'h0, 0, 0));
    // C=1: CS taken, CC not
    tv.push_back(mk(16'h0000, 5'b10000, 16'h0001, 8'h00, 16'h0000, 0, 0, 16'h0000, 4'h0, 4'h0, 1, 1));
    tv.push_back(mk(16'hC2FF, 5'b00000, 16'h0000, 8'h00, 16'h0000, 0, 1, 16'hFFFF, 4'h0, 4'h0, 0, 0));
    tv.push_back(mk(16'hC3FF, 5'b00000, 16'h0000, 8'h00, 16'h0000, 0, 0, 16'hFFFF, 4'h0, 4'h0, 0, 0));
    // N=1 via ANDI (zero-extended imm): GT, GE taken; LE, LT, code 1000 not
    tv.push_back(mk(16'h1780, 5'b00001, 16'h0080, 8'h10, 16'h0080, 1, 0, 16'h0000, 4'h7, 4'h0, 1, 0));
    tv.push_back(mk(16'hC610, 5'b00000, 16'h0000, 8'h00, 16'h0000, 0, 1, 16'h0010, 4'h0, 4'h0, 0, 0));
    tv.push_back(mk(16'hC710, 5'b00000, 16'h0000, 8'h00, 16'h0000, 0, 0, 16'h0010, 4'h0, 4'h0, 0, 0));
    tv.push_back(mk(16'hCC10, 5'b00000, 16'h0000, 8'h00, 16'h0000, 0, 0, 16'h0010, 4'h0, 4'h0, 0, 0));
    tv.push_back(mk(16'hCD10, 5'b00000, 16'h0000, 8'h00, 16'h0000, 0, 1, 16'h0010, 4'h0, 4'h0, 0, 0));
    tv.push_back(mk(16'hC810, 5'b00000, 16'h0000, 8'h00, 16'h0000, 0, 0, 16'h0010, 4'h0, 4'h0, 0, 0));
    // Only L,F set: LT taken, GE and EQ not
    tv.push_back(mk(16'h00B0, 5'b01100, 16'h0000, 8'h0B, 16'h0000, 0, 0, 16'h0000, 4'h0, 4'h0, 1, 1));
    tv.push_back(mk(16'hCC10, 5'b00000, 16'h0000, 8'h00, 16'h0000, 0, 1, 16'h0010, 4'h0, 4'h0, 0, 0));
    tv.push_back(mk(16'hCD10, 5'b00000, 16'h0000, 8'h00, 16'h0000, 0, 0, 16'h0010, 4'h0, 4'h0, 0, 0));
    tv.push_back(mk(16'hC010, 5'b00000, 16'h0000, 8'h00, 16'h0000, 0, 0, 16'h0010, 4'h0, 4'h0, 0, 0));
    tv.push_back(mk(16'h4580, 5'b00000, 16'h0000, 8'h00, 16'h0000, 0, 0, 16'h0000, 4'h0, 4'h0, 0, 0));
    tv.push_back(mk(16'h9380, 5'b00000, 16'h0008, 8'h90, 16'hFF80, 1, 0, 16'h0000, 4'h3, 4'h0, 1, 0));
    tv.push_back(mk(16'h3F7F, 5'b00000, 16'h8000, 8'h30, 16'h007F, 1, 0, 16'h0000, 4'hF, 4'h0, 1, 0));

    reset = 1'b0; en = 1'b0; instr_in = 16'h0000; flags_in = 5'd0;
    #3;
    chk("rst_state", 16'(state_out), 16'd0);
    chk("rst_outs", 16'(|{wEnable, opcode, Rdest_select, Rsrc_select, Imm_in, Imm_select, ram_we,
                          ls_addr_sel, fsm_alu_mem_selct, pc_en, pc_mux_selct, inst_branch,
                          load_en, halted}), 16'd0);
    tick(); tick();
    reset = 1'b1; en = 1'b1;

    foreach (tv[i]) begin
      cur = i;
      run_vec(tv[i]);
    end
    cur = -1;

    // LOAD r3,[r4]: four cycles, write-back from RAM in S_LDWB
    instr_in = 16'h4304; flags_in = 5'd0;
    tick(); tick();
    chk("ld_exec_state", 16'(state_out), 16'd2);
    chk("ld_exec_ls", 16'(ls_addr_sel), 16'd1);
    chk("ld_exec_rdest", 16'(Rdest_select), 16'd4);
    chk("ld_exec_pc_en", 16'(pc_en), 16'd0);
    chk("ld_exec_wen", wEnable, 16'h0000);
    tick();
    chk("ld_wb_state", 16'(state_out), 16'd3);
    chk("ld_wb_src", 16'(fsm_alu_mem_selct), 16'd0);
    chk("ld_wb_wen", wEnable, 16'h0008);
    chk("ld_wb_pc_en", 16'(pc_en), 16'd1);
    tick();
    chk("ld_done_state", 16'(state_out), 16'd0);
    chk("ld_done_wen", wEnable, 16'h0000);

    // STOR r5,[r6]: one-cycle write strobe
    instr_in = 16'h4546;
    tick(); tick();
    chk("st_ram_we", 16'(ram_we), 16'd1);
    chk("st_rsrc", 16'(Rsrc_select), 16'd5);
    chk("st_rdest", 16'(Rdest_select), 16'd6);
    chk("st_ls", 16'(ls_addr_sel), 16'd1);
    tick();
    chk("st_after_state", 16'(state_out), 16'd0);
    chk("st_after_we", 16'(ram_we), 16'd0);

    // STOR again with en dropped in S_EXEC
    tick(); tick();
    en = 1'b0;
    #1;
    chk("en0_ram_we", 16'(ram_we), 16'd0);
    chk("en0_pc_en", 16'(pc_en), 16'd0);
    tick();
    chk("en0_hold_state", 16'(state_out), 16'd2);
    chk("en0_hold_we", 16'(ram_we), 16'd0);
    en = 1'b1;
    #1;
    chk("en1_ram_we", 16'(ram_we), 16'd1);
    tick();
    chk("en1_after_state", 16'(state_out), 16'd0);
    chk("en1_after_we", 16'(ram_we), 16'd0);

    // LOAD interrupted by an asynchronous reset in S_LDWB
    instr_in = 16'h4304;
    tick(); tick(); tick();
    chk("rld_pre_state", 16'(state_out), 16'd3);
    chk("rld_pre_wen", wEnable, 16'h0008);
    reset = 1'b0;
    #1;
    chk("rld_wen", wEnable, 16'h0000);
    chk("rld_pc_en", 16'(pc_en), 16'd0);
    chk("rld_ls", 16'(ls_addr_sel), 16'd0);
    chk("rld_state", 16'(state_out), 16'd0);
    tick();
    reset = 1'b1;

    // HALT: only reset leaves S_HALT
    instr_in = 16'hF000;
    tick(); tick();
    chk("halt_exec_pc_en", 16'(pc_en), 16'd0);
    instr_in = 16'h5103;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("halt_state", 16'(state_out), 16'd4);
      chk("halt_flag", 16'(halted), 16'd1);
      chk("halt_pc_en", 16'(pc_en), 16'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
